// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type encodings and the
// default data width used by the UART block.
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter for the UART receiver.
// The decision strobe fires on the cycle holding the third (mid-bit+1)
// sample, so the bit value registered by the caller is valid from edge
// PRESCALE/2+2 of the bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sample_valid,
    output logic               sample_bit,
    output logic               bit_end
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic               s0_q, s0_d;
    logic               s1_q, s1_d;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] last;

    // Edge counter runs while a frame is active and clears whenever the
    // receiver is heading back to IDLE; the first two votes are captured here.
    always_comb begin
        half       = {1'b0, prescale[PRESC_W-1:1]};
        last       = prescale - PRESC_W'(1);
        edge_cnt_d = edge_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        if (!run) begin
            edge_cnt_d = '0;
        end else if (edge_cnt_q == last) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        end
        if (edge_cnt_q == half - PRESC_W'(1)) begin
            s0_d = rx_in;
        end
        if (edge_cnt_q == half) begin
            s1_d = rx_in;
        end
    end

    // Counter and vote registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

    assign sample_valid = (edge_cnt_q == half + PRESC_W'(1));
    assign sample_bit   = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
    assign bit_end      = (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first data capture, optional parity
// check and stop-bit check. Results are reported with one-cycle pulses; the
// stop decision is taken at mid-stop so back-to-back frames are not missed.
module uart_rx
    import uart_pkg::*;
#(
    parameter int width   = DATA_WIDTH,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] PRESCALE,
    output logic [width-1:0]   P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int BIT_W = (width > 1) ? $clog2(width) : 1;

    uart_state_e        state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [width-1:0]   shift_q, shift_d;
    logic [width-1:0]   p_data_q, p_data_d;
    logic               data_valid_q, data_valid_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;
    logic               par_flag_q, par_flag_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               run;
    logic [PRESC_W-1:0] presc_mux;
    logic               sample_valid;
    logic               sample_bit;
    logic               bit_end;
    logic               par_expect;

    // Before the frame configuration is latched, the live PRESCALE drives the counter.
    assign presc_mux = (state_q == IDLE) ? PRESCALE : presc_q;
    assign run       = (state_d != IDLE);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk          (CLK),
        .rst_n        (RST),
        .run          (run),
        .rx_in        (RX_IN),
        .prescale     (presc_mux),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit),
        .bit_end      (bit_end)
    );

    // Next-state logic, bit capture, parity/stop checks and result pulses.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        par_flag_d   = par_flag_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        presc_d      = presc_q;
        par_expect   = (par_typ_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    presc_d    = PRESCALE;
                    bit_cnt_d  = '0;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (sample_valid && sample_bit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_valid) begin
                    shift_d = {sample_bit, shift_q[width-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(width - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_valid && (sample_bit != par_expect)) begin
                    par_flag_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_valid) begin
                    state_d = IDLE;
                    if (!sample_bit) begin
                        stp_err_d = 1'b1;
                        par_err_d = par_flag_q;
                    end else if (par_flag_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            presc_q      <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_flag_q   <= par_flag_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            presc_q      <= presc_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule
